// File: rtl/mem_stage.sv
// mem_stage: RV64 memory-access stage between EX/MEM and ME/WB.
// Issues loads and stores over a valid/ready request channel with a valid-only
// response channel. It stalls the pipeline while an access is outstanding and
// formats load data into me_outMem.
// Optional feature: define MISALIGN_TRAP_EN to add me_misalign. Misaligned
// accesses then complete with no request, and their register write is suppressed.
module mem_stage #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipeline_en,
   input  logic              ex_memRead,
   input  logic              ex_memWrite,
   input  logic [2:0]        ex_funct3,
   input  logic [XLEN-1:0]   ex_outAlu,
   input  logic [XLEN-1:0]   ex_storeData,
   input  logic              ex_aluOut_WB_memOut,
   input  logic              ex_writeReg,
   input  logic [4:0]        ex_rd,
   output logic              me_aluOut_WB_memOut,
   output logic              me_writeReg,
   output logic [XLEN-1:0]   me_outAlu,
   output logic [4:0]        me_rd,
   output logic [XLEN-1:0]   me_outMem,
   output logic              me_stall,
`ifdef MISALIGN_TRAP_EN
   output logic              me_misalign,
`endif
   output logic              dm_req_valid,
   input  logic              dm_req_ready,
   output logic              dm_req_we,
   output logic [ADDR_W-1:0] dm_req_addr,
   output logic [XLEN-1:0]   dm_req_wdata,
   output logic [7:0]        dm_req_wstrb,
   input  logic              dm_rsp_valid,
   input  logic [XLEN-1:0]   dm_rsp_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t            state, state_nxt;
   logic              op;
   logic              is_store;
   logic [2:0]        off;
   logic [7:0]        strb_base;
   logic              misaligned;
   logic [2:0]        req_funct3;
   logic [2:0]        req_off;
   logic              mis_q;

   assign op       = ex_memRead | ex_memWrite;
   // A load wins when both memRead and memWrite are set.
   assign is_store = ex_memWrite & ~ex_memRead;
   assign off      = ex_outAlu[2:0];

   // Non-memory fields pass straight through to ME/WB.
   assign me_aluOut_WB_memOut = ex_aluOut_WB_memOut;
   assign me_outAlu           = ex_outAlu;
   assign me_rd               = ex_rd;

   // Stall until the access reaches DONE. Stall is never asserted while in reset.
   assign me_stall     = rst_n & op & (state != S_DONE);
   assign dm_req_valid = (state == S_REQ);

`ifdef MISALIGN_TRAP_EN
   // Misalignment check, based on the access size in funct3[1:0].
   always_comb begin
      misaligned = 1'b0;
      case (ex_funct3[1:0])
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = (off[1:0] != 2'b00);
         2'b11:   misaligned = (off != 3'b000);
         default: misaligned = 1'b0;
      endcase
   end
   assign me_misalign = (state == S_DONE) & mis_q;
   assign me_writeReg = ex_writeReg & ~me_misalign;
`else
   assign misaligned  = 1'b0;
   assign me_writeReg = ex_writeReg;
`endif

   // Base byte strobe for each store size. Doubleword stores always write all lanes.
   always_comb begin
      strb_base = 8'hFF;
      case (ex_funct3[1:0])
         2'b00:   strb_base = 8'h01 << off;
         2'b01:   strb_base = 8'h03 << off;
         2'b10:   strb_base = 8'h0F << off;
         default: strb_base = 8'hFF;
      endcase
   end

   // Select the addressed lane of the read data, then sign- or zero-extend it.
   function automatic logic [63:0] fmt_load(input logic [2:0] f3, input logic [2:0] o,
                                            input logic [63:0] d);
      logic [63:0] lane;
      lane = d >> {o, 3'b000};
      case (f3)
         3'b000:  return {{56{lane[7]}},  lane[7:0]};
         3'b001:  return {{48{lane[15]}}, lane[15:0]};
         3'b010:  return {{32{lane[31]}}, lane[31:0]};
         3'b100:  return {56'd0, lane[7:0]};
         3'b101:  return {48'd0, lane[15:0]};
         3'b110:  return {32'd0, lane[31:0]};
         default: return lane;
      endcase
   endfunction

   // Access FSM state register.
   // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic for the access FSM.
   // NOTE: the default assignment first keeps this block from inferring a latch on paths that do not assign it.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (op)           state_nxt = misaligned ? S_DONE : S_REQ;
         S_REQ:  if (dm_req_ready) state_nxt = dm_req_we ? S_DONE : S_WAIT;
         S_WAIT: if (dm_rsp_valid) state_nxt = S_DONE;
         S_DONE: if (pipeline_en)  state_nxt = S_IDLE;
         default:                  state_nxt = S_IDLE;
      endcase
   end

   // Latch the request fields on issue, so they stay stable until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dm_req_we    <= 1'b0;
         dm_req_addr  <= '0;
         dm_req_wdata <= '0;
         dm_req_wstrb <= 8'h00;
         req_funct3   <= 3'b000;
         req_off      <= 3'b000;
      end else if (state == S_IDLE && op) begin
         dm_req_we    <= is_store;
         dm_req_addr  <= ADDR_W'({ex_outAlu[XLEN-1:3], 3'b000});
         dm_req_wdata <= ex_storeData << {off, 3'b000};
         dm_req_wstrb <= strb_base;
         req_funct3   <= ex_funct3;
         req_off      <= off;
      end
   end

   // Load-data register. It is written only by a captured response, or cleared by a misalign trap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  me_outMem <= '0;
      else if (state == S_WAIT && dm_rsp_valid)    me_outMem <= fmt_load(req_funct3, req_off, dm_rsp_rdata);
      else if (state == S_IDLE && op && misaligned) me_outMem <= '0;
   end

   // Remember whether the access that reached DONE was a misalign trap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                mis_q <= 1'b0;
      else if (state == S_IDLE)  mis_q <= op & misaligned;
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed test of mem_stage with hand-computed expected values.
// Build with MISALIGN_TRAP_EN defined to cover the misalign trap as well.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pipeline_en = 1'b1;
   logic        ex_memRead = 1'b0, ex_memWrite = 1'b0;
   logic [2:0]  ex_funct3 = 3'b000;
   logic [63:0] ex_outAlu = '0, ex_storeData = '0;
   logic        ex_aluOut_WB_memOut = 1'b0, ex_writeReg = 1'b0;
   logic [4:0]  ex_rd = '0;
   logic        me_aluOut_WB_memOut, me_writeReg, me_stall;
   logic [63:0] me_outAlu, me_outMem;
   logic [4:0]  me_rd;
   logic        dm_req_valid, dm_req_we;
   logic        dm_req_ready = 1'b0;
   logic [63:0] dm_req_addr, dm_req_wdata;
   logic [7:0]  dm_req_wstrb;
   logic        dm_rsp_valid = 1'b0;
   logic [63:0] dm_rsp_rdata = '0;
`ifdef MISALIGN_TRAP_EN
   logic        me_misalign;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   mem_stage dut (
      .clk(clk), .rst_n(rst_n), .pipeline_en(pipeline_en),
      .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_funct3(ex_funct3),
      .ex_outAlu(ex_outAlu), .ex_storeData(ex_storeData),
      .ex_aluOut_WB_memOut(ex_aluOut_WB_memOut), .ex_writeReg(ex_writeReg), .ex_rd(ex_rd),
      .me_aluOut_WB_memOut(me_aluOut_WB_memOut), .me_writeReg(me_writeReg),
      .me_outAlu(me_outAlu), .me_rd(me_rd), .me_outMem(me_outMem), .me_stall(me_stall),
`ifdef MISALIGN_TRAP_EN
      .me_misalign(me_misalign),
`endif
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
      .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb),
      .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count the stall cycles until DONE. The wait is bounded, so a hung FSM shows up as a wrong count.
   task automatic run_op(output int stalls);
      stalls = 0;
      #1;
      while (me_stall && stalls < 40) begin
         stalls++;
         tick();
      end
   endtask

   typedef struct packed {
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] rdata;
      logic [63:0] exp;
   } ld_vec_t;

   ld_vec_t ld_tab [7] = '{
      '{3'b000, 64'h1003, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80},  // LB
      '{3'b001, 64'h0102, 64'h00000000_ABCD0000, 64'hFFFFFFFF_FFFFABCD},  // LH
      '{3'b010, 64'h0204, 64'h87654321_00000000, 64'hFFFFFFFF_87654321},  // LW
      '{3'b011, 64'h0300, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF},  // LD
      '{3'b101, 64'h0406, 64'hFEDC0000_00000000, 64'h00000000_0000FEDC},  // LHU
      '{3'b100, 64'h0507, 64'h9A000000_00000000, 64'h00000000_0000009A},  // LBU
      '{3'b111, 64'h0600, 64'h55AA55AA_00FF00FF, 64'h55AA55AA_00FF00FF}   // 111 = LD
   };

   int st;

   initial begin
      // Reset state. A pending load must not raise stall while in reset.
      ex_memRead = 1'b1;
      #2;
      check("rst_stall", 64'(me_stall), 64'd0);
      check("rst_valid", 64'(dm_req_valid), 64'd0);
      check("rst_outmem", me_outMem, 64'd0);
`ifdef MISALIGN_TRAP_EN
      check("rst_misalign", 64'(me_misalign), 64'd0);
`endif
      ex_memRead = 1'b0;
      #6 rst_n = 1'b1;
      tick();

      // ALU op: combinational pass-through, no stall, no request.
      ex_outAlu = 64'hDEAD_0000_1234_5678; ex_rd = 5'd7; ex_writeReg = 1'b1; ex_aluOut_WB_memOut = 1'b1;
      #1;
      check("alu_stall", 64'(me_stall), 64'd0);
      check("alu_outalu", me_outAlu, 64'hDEAD_0000_1234_5678);
      check("alu_rd", 64'(me_rd), 64'd7);
      check("alu_wreg", 64'(me_writeReg), 64'd1);
      check("alu_wbsel", 64'(me_aluOut_WB_memOut), 64'd1);
      tick();
      check("alu_noreq", 64'(dm_req_valid), 64'd0);

      // Loads with ready and response always high: 3 stall cycles each.
      dm_req_ready = 1'b1; dm_rsp_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         ex_memRead = 1'b1; ex_funct3 = ld_tab[i].f3; ex_outAlu = ld_tab[i].addr;
         dm_rsp_rdata = ld_tab[i].rdata;
         run_op(st);
         check($sformatf("ld%0d_stalls", i), 64'(st), 64'd3);
         check($sformatf("ld%0d_data", i), me_outMem, ld_tab[i].exp);
         tick();
      end
      // The last load left 0x55AA55AA_00FF00FF. Reload LB so the store checks see a known value.
      ex_funct3 = ld_tab[0].f3; ex_outAlu = ld_tab[0].addr; dm_rsp_rdata = ld_tab[0].rdata;
      run_op(st);
      check("lb_data", me_outMem, 64'hFFFFFFFF_FFFFFF80);
      tick();
      ex_memRead = 1'b0; dm_rsp_valid = 1'b0;

      // SH at 0x2006 with ready held low for 4 cycles: the request must stay stable.
      ex_memWrite = 1'b1; ex_funct3 = 3'b001; ex_outAlu = 64'h2006; ex_storeData = 64'hBEEF;
      dm_req_ready = 1'b0;
      #1;
      check("sh_idle_stall", 64'(me_stall), 64'd1);
      check("sh_idle_valid", 64'(dm_req_valid), 64'd0);
      tick();
      for (int c = 0; c < 4; c++) begin
         check("sh_hold_valid", 64'(dm_req_valid), 64'd1);
         check("sh_hold_addr", dm_req_addr, 64'h2000);
         check("sh_hold_we", 64'(dm_req_we), 64'd1);
         check("sh_hold_wstrb", 64'(dm_req_wstrb), 64'hC0);
         check("sh_hold_wdata", dm_req_wdata, 64'hBEEF_0000_0000_0000);
         check("sh_hold_stall", 64'(me_stall), 64'd1);
         tick();
      end
      dm_req_ready = 1'b1;
      #1;
      check("sh_acc_valid", 64'(dm_req_valid), 64'd1);
      tick();
      check("sh_done_stall", 64'(me_stall), 64'd0);
      check("sh_done_valid", 64'(dm_req_valid), 64'd0);
      check("sh_outmem_kept", me_outMem, 64'hFFFFFFFF_FFFFFF80);
      tick();

      // SD at 0x10 with ready high: 2 stall cycles, all strobes set.
      ex_funct3 = 3'b011; ex_outAlu = 64'h10; ex_storeData = 64'h11223344_55667788;
      #1;
      check("sd_c0_stall", 64'(me_stall), 64'd1);
      tick();
      check("sd_c1_stall", 64'(me_stall), 64'd1);
      check("sd_wstrb", 64'(dm_req_wstrb), 64'hFF);
      check("sd_wdata", dm_req_wdata, 64'h11223344_55667788);
      tick();
      check("sd_c2_stall", 64'(me_stall), 64'd0);
      tick();

      // memRead and memWrite both high: the op is treated as a load.
      ex_memRead = 1'b1; ex_outAlu = 64'h20; dm_rsp_rdata = 64'h0BAD_F00D_CAFE_BABE;
      #1;
      tick();
      check("rw_we", 64'(dm_req_we), 64'd0);
      tick();
      check("rw_wait_valid", 64'(dm_req_valid), 64'd0);
      dm_rsp_valid = 1'b1;
      tick();
      check("rw_data", me_outMem, 64'h0BAD_F00D_CAFE_BABE);
      tick();
      ex_memWrite = 1'b0;

      // LWU at 0x8, then hold DONE while pipeline_en is low.
      ex_funct3 = 3'b110; ex_outAlu = 64'h8; dm_rsp_rdata = 64'hF0000000_12345678;
      run_op(st);
      check("lwu_stalls", 64'(st), 64'd3);
      check("lwu_data", me_outMem, 64'h00000000_12345678);
      pipeline_en = 1'b0;
      dm_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) begin
         tick();
         check("hold_stall", 64'(me_stall), 64'd0);
         check("hold_valid", 64'(dm_req_valid), 64'd0);
         check("hold_data", me_outMem, 64'h00000000_12345678);
      end
      pipeline_en = 1'b1;
      tick();
      check("hold_exit_idle", 64'(me_stall), 64'd1);
      ex_memRead = 1'b0; dm_rsp_valid = 1'b0;
      #1;
      tick();

`ifdef MISALIGN_TRAP_EN
      // Misaligned LW at 0x2: trap with no request, 1 stall cycle.
      ex_memRead = 1'b1; ex_funct3 = 3'b010; ex_outAlu = 64'h2; ex_writeReg = 1'b1;
      #1;
      check("mis_c0_stall", 64'(me_stall), 64'd1);
      check("mis_c0_valid", 64'(dm_req_valid), 64'd0);
      tick();
      check("mis_stall", 64'(me_stall), 64'd0);
      check("mis_valid", 64'(dm_req_valid), 64'd0);
      check("mis_flag", 64'(me_misalign), 64'd1);
      check("mis_wreg", 64'(me_writeReg), 64'd0);
      check("mis_outmem", me_outMem, 64'd0);
      tick();
      check("mis_flag_clr", 64'(me_misalign), 64'd0);
      ex_memRead = 1'b0;
      #1;
      tick();
`endif

      // Reset pulsed while in WAIT, followed by a late response that must be ignored.
      ex_memRead = 1'b1; ex_funct3 = 3'b000; ex_outAlu = 64'h40; dm_req_ready = 1'b1; dm_rsp_valid = 1'b0;
      #1;
      tick();
      tick();
      check("wr_wait_stall", 64'(me_stall), 64'd1);
      check("wr_wait_valid", 64'(dm_req_valid), 64'd0);
      rst_n = 1'b0;
      #2;
      check("wr_rst_stall", 64'(me_stall), 64'd0);
      check("wr_rst_outmem", me_outMem, 64'd0);
      ex_memRead = 1'b0;
      rst_n = 1'b1;
      #1;
      dm_rsp_valid = 1'b1; dm_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      check("wr_stale_outmem", me_outMem, 64'd0);
      check("wr_stale_stall", 64'(me_stall), 64'd0);
      check("wr_stale_valid", 64'(dm_req_valid), 64'd0);
      dm_rsp_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
